coin_dispense_sequencer: RTL and testbench

//  Upstream stage of the servo PWM interface. Accepts a request for N coins and

---
 rtl/atm_pkg.sv | 14 +
 rtl/sync2.sv | 13 +
 rtl/coin_dispense_sequencer.sv | 87 ++++++++
 tb/tb_coin_dispense_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// atm_pkg: shared state encoding and servo position constants for the ATM datapath
package atm_pkg;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      BACK_ACK   = 3'd1,
      BACK_WAIT  = 3'd2,
      FRONT_ACK  = 3'd3,
      FRONT_WAIT = 3'd4,
      FIN        = 3'd5,
      ERR        = 3'd6
   } state_t;
   localparam logic SERVO_BACK  = 1'b1;
   localparam logic SERVO_FRONT = 1'b0;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for an idle-high asynchronous level
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic m;
   // capture the raw level through two stages; reset reads as idle-high
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, m} <= 2'b11;
      else {q, m} <= {m, d};
endmodule

// File: rtl/coin_dispense_sequencer.sv
// coin_dispense_sequencer: drives one back/front servo stroke per requested coin with handshake timeouts
module coin_dispense_sequencer
   import atm_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int ACK_CYCLES  = 1000,
   parameter int MOVE_CYCLES = 40000000,
   parameter int TMR_W       = 26
) (
   input  logic             clk,
   input  logic             timerStart,
   input  logic             req_valid,
   input  logic [CNT_W-1:0] req_count,
   output logic             req_ready,
   input  logic             abort,
   input  logic             servo_back_done,
   input  logic             servo_front_done,
   output logic [31:0]      servo_ctrl,
   output logic             busy,
   output logic [CNT_W-1:0] dispensed,
   output logic             done_pulse,
   output logic             error
);
   state_t state, state_nx;
   logic [CNT_W-1:0] count, count_nx, dispensed_nx;
   logic [TMR_W-1:0] timer;
   logic servo, servo_nx, back_done, front_done, ack_to, move_to, last;

   sync2 u_back  (.clk(clk), .rst(timerStart), .d(servo_back_done),  .q(back_done));
   sync2 u_front (.clk(clk), .rst(timerStart), .d(servo_front_done), .q(front_done));

   assign ack_to     = timer == TMR_W'(ACK_CYCLES);
   assign move_to    = timer == TMR_W'(MOVE_CYCLES);
   assign last       = (dispensed + CNT_W'(1)) == count;
   assign req_ready  = state == IDLE;
   assign busy       = state != IDLE && state != ERR;
   assign done_pulse = state == FIN;
   assign error      = state == ERR;
   assign servo_ctrl = {31'b0, servo};

   // next state and next servo/count values; a done condition beats a timeout
   always_comb begin
      state_nx     = state;
      count_nx     = count;
      dispensed_nx = dispensed;
      servo_nx     = servo;
      case (state)
         IDLE: if (req_valid) begin
            count_nx     = req_count;
            dispensed_nx = '0;
            state_nx     = (req_count == '0) ? FIN : BACK_ACK;
            servo_nx     = (req_count == '0) ? SERVO_FRONT : SERVO_BACK;
         end
         BACK_ACK: state_nx = !back_done ? BACK_WAIT : (ack_to ? ERR : state);
         BACK_WAIT: if (back_done) begin
            state_nx = FRONT_ACK;
            servo_nx = SERVO_FRONT;
         end else if (move_to) state_nx = ERR;
         FRONT_ACK: state_nx = !front_done ? FRONT_WAIT : (ack_to ? ERR : state);
         FRONT_WAIT: if (front_done) begin
            dispensed_nx = dispensed + CNT_W'(1);
            state_nx     = last ? FIN : BACK_ACK;
            servo_nx     = last ? SERVO_FRONT : SERVO_BACK;
         end else if (move_to) state_nx = ERR;
         FIN: state_nx = IDLE;
         ERR: state_nx = abort ? IDLE : state;
         default: state_nx = IDLE;
      endcase
      if (state_nx == ERR) servo_nx = SERVO_FRONT;
   end

   // state, datapath and saturating timer that restarts on every state change
   always_ff @(posedge clk or posedge timerStart)
      if (timerStart) begin
         state     <= IDLE;
         count     <= '0;
         dispensed <= '0;
         servo     <= SERVO_FRONT;
         timer     <= '0;
      end else begin
         state     <= state_nx;
         count     <= count_nx;
         dispensed <= dispensed_nx;
         servo     <= servo_nx;
         timer     <= (state_nx != state) ? '0 : (&timer ? timer : timer + TMR_W'(1));
      end
endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// tb_coin_dispense_sequencer: directed scenarios against a simple servo-stage model
module tb_coin_dispense_sequencer;
   logic clk = 0, timerStart = 1, req_valid = 0, abort = 0;
   logic [7:0] req_count = 0;
   logic req_ready, busy, done_pulse, error;
   logic [31:0] servo_ctrl;
   logic [7:0] dispensed;
   logic bd_m, fd_m, s_prev, block_back = 0, hold_front = 0;
   logic back_done_in, front_done_in;
   int bt, ft, checks = 0, errors = 0;

   assign back_done_in  = bd_m | block_back;
   assign front_done_in = fd_m & !hold_front;

   coin_dispense_sequencer #(.CNT_W(8), .ACK_CYCLES(8), .MOVE_CYCLES(50), .TMR_W(26)) dut (
      .clk(clk), .timerStart(timerStart), .req_valid(req_valid), .req_count(req_count),
      .req_ready(req_ready), .abort(abort), .servo_back_done(back_done_in),
      .servo_front_done(front_done_in), .servo_ctrl(servo_ctrl), .busy(busy),
      .dispensed(dispensed), .done_pulse(done_pulse), .error(error)
   );

   always #5 clk = ~clk;

   // servo stage: done falls 3 cycles after a servo edge, rises 20 cycles later
   always @(posedge clk or posedge timerStart)
      if (timerStart) begin
         bd_m <= 1; fd_m <= 1; s_prev <= 0; bt <= 0; ft <= 0;
      end else begin
         s_prev <= servo_ctrl[0];
         if (servo_ctrl[0] && !s_prev) bt <= 1;
         else if (bt != 0) bt <= (bt == 23) ? 0 : bt + 1;
         if (!servo_ctrl[0] && s_prev) ft <= 1;
         else if (ft != 0) ft <= (ft == 23) ? 0 : ft + 1;
         if (bt == 3) bd_m <= 0;
         if (bt == 23) bd_m <= 1;
         if (ft == 3) fd_m <= 0;
         if (ft == 23) fd_m <= 1;
      end

   task automatic accept(input logic [7:0] c);
      @(negedge clk);
      req_valid = 1; req_count = c;
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (servo_ctrl !== 32'd0) begin errors++; $display("FAIL reset_servo got %0h want 0", servo_ctrl); end
      checks++; if (dispensed !== 8'd0) begin errors++; $display("FAIL reset_disp got %0d want 0", dispensed); end
      checks++; if ({done_pulse, error, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {done_pulse, error, busy}); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
      repeat (3) @(negedge clk);
      timerStart = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_three_coins;
      int edges = 0, steps = 0, bad = 0, pulses = 0;
      logic ps = 0;
      logic [7:0] pd = 0;
      accept(8'd3);
      for (int i = 0; i < 250; i++) begin
         if (servo_ctrl[0] !== ps) edges++;
         ps = servo_ctrl[0];
         if (dispensed !== pd) begin steps++; if (dispensed !== pd + 8'd1) bad++; pd = dispensed; end
         if (done_pulse) pulses++;
         @(negedge clk);
         abort = (i == 40);
      end
      abort = 0;
      checks++; if (edges !== 6) begin errors++; $display("FAIL three_edges got %0d want 6", edges); end
      checks++; if (steps !== 3 || bad !== 0) begin errors++; $display("FAIL three_steps got %0d/%0d want 3/0", steps, bad); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL three_pulses got %0d want 1", pulses); end
      checks++; if (dispensed !== 8'd3) begin errors++; $display("FAIL three_disp got %0d want 3", dispensed); end
      checks++; if ({busy, req_ready, servo_ctrl[0]} !== 3'b010) begin errors++; $display("FAIL three_idle got %b want 010", {busy, req_ready, servo_ctrl[0]}); end
   endtask

   task automatic test_zero_count;
      accept(8'd0);
      checks++; if ({done_pulse, busy} !== 2'b11) begin errors++; $display("FAIL zero_pulse got %b want 11", {done_pulse, busy}); end
      checks++; if (dispensed !== 8'd0) begin errors++; $display("FAIL zero_disp got %0d want 0", dispensed); end
      checks++; if (servo_ctrl !== 32'd0) begin errors++; $display("FAIL zero_servo got %0h want 0", servo_ctrl); end
      @(negedge clk);
      checks++; if ({done_pulse, busy, req_ready} !== 3'b001) begin errors++; $display("FAIL zero_after got %b want 001", {done_pulse, busy, req_ready}); end
   endtask

   task automatic test_ack_timeout;
      int n = 0;
      block_back = 1;
      accept(8'd2);
      checks++; if (servo_ctrl[0] !== 1'b1) begin errors++; $display("FAIL ackto_servo1 got %b want 1", servo_ctrl[0]); end
      while (!error && n < 100) begin @(negedge clk); n++; end
      checks++; if (n !== 9) begin errors++; $display("FAIL ackto_cycles got %0d want 9", n); end
      checks++; if ({servo_ctrl[0], busy, req_ready} !== 3'b000) begin errors++; $display("FAIL ackto_err got %b want 000", {servo_ctrl[0], busy, req_ready}); end
      checks++; if (dispensed !== 8'd0) begin errors++; $display("FAIL ackto_disp got %0d want 0", dispensed); end
      abort = 1;
      @(negedge clk);
      abort = 0;
      checks++; if ({error, req_ready} !== 2'b01) begin errors++; $display("FAIL ackto_abort got %b want 01", {error, req_ready}); end
      block_back = 0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_move_timeout;
      int n = 0;
      accept(8'd3);
      while (dispensed !== 8'd1 && n < 200) begin @(negedge clk); n++; end
      hold_front = 1;
      n = 0;
      while (!error && n < 300) begin @(negedge clk); n++; end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL moveto_err got %b want 1", error); end
      checks++; if (dispensed !== 8'd1) begin errors++; $display("FAIL moveto_disp got %0d want 1", dispensed); end
      checks++; if (servo_ctrl[0] !== 1'b0) begin errors++; $display("FAIL moveto_servo got %b want 0", servo_ctrl[0]); end
      req_valid = 1; req_count = 8'd1;
      repeat (10) @(negedge clk);
      checks++; if ({error, req_ready, busy} !== 3'b100) begin errors++; $display("FAIL moveto_ignore got %b want 100", {error, req_ready, busy}); end
      checks++; if (dispensed !== 8'd1) begin errors++; $display("FAIL moveto_hold got %0d want 1", dispensed); end
      req_valid = 0; abort = 1;
      @(negedge clk);
      abort = 0;
      checks++; if ({error, req_ready, dispensed} !== {2'b01, 8'd1}) begin errors++; $display("FAIL moveto_abort got %b/%0d want 01/1", {error, req_ready}, dispensed); end
      hold_front = 0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_async_reset;
      int n = 0;
      accept(8'd2);
      repeat (12) @(negedge clk);
      checks++; if ({busy, servo_ctrl[0]} !== 2'b11) begin errors++; $display("FAIL arst_pre got %b want 11", {busy, servo_ctrl[0]}); end
      #2 timerStart = 1;
      #1;
      checks++; if (servo_ctrl !== 32'd0) begin errors++; $display("FAIL arst_servo got %0h want 0", servo_ctrl); end
      checks++; if ({busy, done_pulse, error, req_ready} !== 4'b0001) begin errors++; $display("FAIL arst_flags got %b want 0001", {busy, done_pulse, error, req_ready}); end
      checks++; if (dispensed !== 8'd0) begin errors++; $display("FAIL arst_disp got %0d want 0", dispensed); end
      #1 timerStart = 0;
      repeat (2) @(negedge clk);
      accept(8'd1);
      while (!done_pulse && n < 200) begin @(negedge clk); n++; end
      checks++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL arst_done got %b want 1", done_pulse); end
      checks++; if (dispensed !== 8'd1) begin errors++; $display("FAIL arst_count got %0d want 1", dispensed); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n = 0, bad = 0;
      @(negedge clk);
      req_valid = 1; req_count = 8'd2;
      @(negedge clk);
      while (!done_pulse && n < 200) begin if (req_ready !== 1'b0) bad++; @(negedge clk); n++; end
      checks++; if (done_pulse !== 1'b1 || bad !== 0) begin errors++; $display("FAIL b2b_first got %b/%0d want 1/0", done_pulse, bad); end
      checks++; if (dispensed !== 8'd2) begin errors++; $display("FAIL b2b_disp1 got %0d want 2", dispensed); end
      @(negedge clk);
      checks++; if ({req_ready, busy, dispensed} !== {2'b10, 8'd2}) begin errors++; $display("FAIL b2b_idle got %b/%0d want 10/2", {req_ready, busy}, dispensed); end
      @(negedge clk);
      req_valid = 0;
      checks++; if ({busy, servo_ctrl[0], dispensed} !== {2'b11, 8'd0}) begin errors++; $display("FAIL b2b_second got %b/%0d want 11/0", {busy, servo_ctrl[0]}, dispensed); end
      n = 0;
      while (!done_pulse && n < 200) begin @(negedge clk); n++; end
      checks++; if ({done_pulse, dispensed} !== {1'b1, 8'd2}) begin errors++; $display("FAIL b2b_done got %b/%0d want 1/2", done_pulse, dispensed); end
   endtask

   initial begin
      test_reset;
      test_three_coins;
      test_zero_count;
      test_ack_timeout;
      test_move_timeout;
      test_async_reset;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
